cell_sweep_misr: RTL



---
 rtl/cell_sweep_misr.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cell_sweep_misr.sv
`default_nettype none
// ============================================================================
// cell_sweep_misr : sweeps all 64 cell input vectors of one page and folds the
//                   8-bit cell response into a 16-bit MISR signature.
// Revision: 1.0
// ============================================================================
module cell_sweep_misr #(
   parameter int unsigned SETTLE = 2,
   parameter logic [15:0] SEED   = 16'hFFFF,
   parameter logic [15:0] POLY   = 16'h100B
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [4:0]  page_sel,
   input  logic [7:0]  cell_out,
   output logic [4:0]  page,
   output logic [5:0]  cell_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_APPLY  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
   localparam logic [5:0] VEC_LAST = 6'd63;

   state_e      state_q, state_d;
   logic [4:0]  page_q, page_d;
   logic [5:0]  cell_in_q, cell_in_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] sig_q, sig_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] misr_next;
   logic        start_ok;

   // Galois-style shift with the response folded into the low byte.
   always_comb begin
      misr_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000)
                  ^ {8'h00, cell_out};
   end

   // In DONE a start always restarts; in IDLE abort takes priority over start.
   always_comb begin
      start_ok = start && ((state_q == S_DONE) || !abort);
   end

   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      cell_in_d = cell_in_q;
      cnt_d     = cnt_q;
      sig_d     = sig_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
               state_d   = S_APPLY;
               page_d    = page_sel;
               cell_in_d = 6'd0;
               cnt_d     = 4'd0;
               sig_d     = SEED;
            end
         end
         S_APPLY: begin
            if (abort) begin
               state_d   = S_IDLE;
               cell_in_d = 6'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_SAMPLE;
               end
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_d   = S_IDLE;
               cell_in_d = 6'd0;
            end else begin
               sig_d = misr_next;
               if (cell_in_q == VEC_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_APPLY;
                  cell_in_d = cell_in_q + 6'd1;
                  cnt_d     = 4'd0;
               end
            end
         end
         default: begin
            state_d   = S_IDLE;
            cell_in_d = 6'd0;
         end
      endcase

      busy_d = (state_d == S_APPLY) || (state_d == S_SAMPLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         page_q    <= 5'd0;
         cell_in_q <= 6'd0;
         cnt_q     <= 4'd0;
         sig_q     <= SEED;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         page_q    <= page_d;
         cell_in_q <= cell_in_d;
         cnt_q     <= cnt_d;
         sig_q     <= sig_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign page      = page_q;
   assign cell_in   = cell_in_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign signature = sig_q;

endmodule
`default_nettype wire
